// File: rtl/can_err_pkg.sv
// Shared encodings, limits and the node-state decode for the CAN
// fault-confinement controller.
package can_err_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_WAIT_DELIM,
    S_DELIM,
    S_BUSOFF
  } seq_state_t;

  typedef enum logic [1:0] {
    NS_ACTIVE  = 2'b00,
    NS_PASSIVE = 2'b01,
    NS_BUSOFF  = 2'b10
  } node_state_t;

  localparam logic [9:0] PASSIVE_LIM = 10'd128;
  localparam logic [9:0] BUSOFF_LIM  = 10'd256;
  localparam logic [3:0] RECOV_RUN   = 4'd11;
  localparam logic [9:0] TX_INC      = 10'd8;
  localparam logic [8:0] RX_INC      = 9'd1;
  localparam logic [7:0] REC_RELOAD  = 8'd120;
  localparam logic [7:0] REC_MAX     = 8'd255;

  function automatic node_state_t node_decode(input logic [8:0] tec, input logic [7:0] rec);
    if ({1'b0, tec} >= BUSOFF_LIM)
      return NS_BUSOFF;
    else if (({1'b0, tec} >= PASSIVE_LIM) || ({2'b00, rec} >= PASSIVE_LIM))
      return NS_PASSIVE;
    else
      return NS_ACTIVE;
  endfunction

endpackage

// File: rtl/can_err_counters.sv
// TEC/REC arithmetic with saturation, plus node-state decode of both the
// current and the about-to-be-registered counter values.
module can_err_counters
  import can_err_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_err,
  input  logic       i_ok,
  input  logic       i_tx_mode,
  input  logic       i_clr,
  output logic [8:0] o_tec,
  output logic [7:0] o_rec,
  output logic [1:0] o_node_state,
  output logic       o_busoff_nxt,
  output logic       o_passive_nxt
);

  logic [8:0] r_tec;
  logic [7:0] r_rec;
  logic [8:0] w_tec_nxt;
  logic [7:0] w_rec_nxt;

  function automatic logic [8:0] tec_sat_add(input logic [8:0] tec);
    logic [9:0] sum;
    sum = {1'b0, tec} + TX_INC;
    return (sum >= BUSOFF_LIM) ? BUSOFF_LIM[8:0] : sum[8:0];
  endfunction

  function automatic logic [7:0] rec_sat_add(input logic [7:0] rec);
    logic [8:0] sum;
    sum = {1'b0, rec} + RX_INC;
    return (sum > {1'b0, REC_MAX}) ? REC_MAX : sum[7:0];
  endfunction

  // A receiver that was error-passive drops straight back to the reload value.
  function automatic logic [7:0] rec_frame_ok(input logic [7:0] rec);
    if ({2'b00, rec} >= PASSIVE_LIM)
      return REC_RELOAD;
    else if (rec != 8'd0)
      return rec - 8'd1;
    else
      return rec;
  endfunction

  always_comb begin
    w_tec_nxt = r_tec;
    w_rec_nxt = r_rec;
    if (i_clr) begin
      w_tec_nxt = 9'd0;
      w_rec_nxt = 8'd0;
    end else if (i_err) begin
      if (i_tx_mode) w_tec_nxt = tec_sat_add(r_tec);
      else           w_rec_nxt = rec_sat_add(r_rec);
    end else if (i_ok) begin
      if (i_tx_mode) w_tec_nxt = (r_tec != 9'd0) ? (r_tec - 9'd1) : r_tec;
      else           w_rec_nxt = rec_frame_ok(r_rec);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tec <= 9'd0;
      r_rec <= 8'd0;
    end else begin
      r_tec <= w_tec_nxt;
      r_rec <= w_rec_nxt;
    end
  end

  assign o_tec         = r_tec;
  assign o_rec         = r_rec;
  assign o_node_state  = node_decode(r_tec, r_rec);
  assign o_busoff_nxt  = (node_decode(w_tec_nxt, w_rec_nxt) == NS_BUSOFF);
  assign o_passive_nxt = (node_decode(w_tec_nxt, w_rec_nxt) != NS_ACTIVE);

endmodule

// File: rtl/can_error_ctrl.sv
// CAN fault confinement: error-frame sequencer and bus-off recovery around
// the TEC/REC counter block.
module can_error_ctrl
  import can_err_pkg::*;
#(
  parameter int FLAG_LEN  = 6,
  parameter int DELIM_LEN = 8,
  parameter int RECOV_CNT = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SP,
  input  logic       STF_E,
  input  logic       EOF_E,
  input  logic       CRC_E,
  input  logic       FRM_E,
  input  logic       RX_BIT,
  input  logic       TX_MODE,
  input  logic       FRAME_OK,
  output logic       TX_BIT,
  output logic       ERR_BUSY,
  output logic [8:0] TEC,
  output logic [7:0] REC,
  output logic [1:0] NODE_STATE,
  output logic       RESTART
);

  localparam int CNT_MAX = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int OCC_W   = $clog2(RECOV_CNT + 1);
  localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_LEN - 1);
  localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_LEN - 1);
  localparam logic [OCC_W-1:0] OCC_LAST   = OCC_W'(RECOV_CNT - 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [3:0]       r_run;
  logic [OCC_W-1:0] r_occ;

  logic w_ev_raw, w_cnt_err, w_cnt_ok, w_run_done, w_clr;
  logic w_busoff_nxt, w_passive_nxt;

  // Errors only count from IDLE or as a form error inside the delimiter;
  // flags seen during FLAG/WAIT_DELIM belong to the error already signalled.
  assign w_ev_raw   = SP && !(STF_E && EOF_E && CRC_E && FRM_E);
  assign w_cnt_err  = ((r_state == S_IDLE) && w_ev_raw) ||
                      ((r_state == S_DELIM) && SP && (w_ev_raw || !RX_BIT));
  assign w_cnt_ok   = FRAME_OK && (r_state == S_IDLE) && !w_cnt_err;
  assign w_run_done = SP && RX_BIT && (r_run == (RECOV_RUN - 4'd1));
  assign w_clr      = (r_state == S_BUSOFF) && w_run_done && (r_occ == OCC_LAST);

  can_err_counters u_counters (
    .clock         (clock),
    .reset         (reset),
    .i_err         (w_cnt_err),
    .i_ok          (w_cnt_ok),
    .i_tx_mode     (TX_MODE),
    .i_clr         (w_clr),
    .o_tec         (TEC),
    .o_rec         (REC),
    .o_node_state  (NODE_STATE),
    .o_busoff_nxt  (w_busoff_nxt),
    .o_passive_nxt (w_passive_nxt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_run     <= 4'd0;
      r_occ     <= '0;
      TX_BIT    <= 1'b1;
      ERR_BUSY  <= 1'b0;
      RESTART   <= 1'b0;
    end else begin
      RESTART <= 1'b0;
      if (w_busoff_nxt && (r_state != S_BUSOFF)) begin
        r_state   <= S_BUSOFF;
        r_bit_cnt <= '0;
        r_run     <= 4'd0;
        r_occ     <= '0;
        TX_BIT    <= 1'b1;
        ERR_BUSY  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cnt_err) begin
              r_state   <= S_FLAG;
              r_bit_cnt <= '0;
              TX_BIT    <= w_passive_nxt;
              ERR_BUSY  <= 1'b1;
            end
          end
          S_FLAG: begin
            if (SP) begin
              if (r_bit_cnt == FLAG_LAST) begin
                r_state <= S_WAIT_DELIM;
                TX_BIT  <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          S_WAIT_DELIM: begin
            if (SP && RX_BIT) begin
              r_state   <= S_DELIM;
              r_bit_cnt <= CNT_W'(1);
            end
          end
          S_DELIM: begin
            if (w_cnt_err) begin
              r_state   <= S_FLAG;
              r_bit_cnt <= '0;
              TX_BIT    <= w_passive_nxt;
            end else if (SP) begin
              if (r_bit_cnt == DELIM_LAST) begin
                r_state  <= S_IDLE;
                ERR_BUSY <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          S_BUSOFF: begin
            if (SP) begin
              if (!RX_BIT) begin
                r_run <= 4'd0;
              end else if (w_run_done) begin
                r_run <= 4'd0;
                if (w_clr) begin
                  r_occ   <= '0;
                  r_state <= S_IDLE;
                  RESTART <= 1'b1;
                end else begin
                  r_occ <= r_occ + OCC_W'(1);
                end
              end else begin
                r_run <= r_run + 4'd1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_error_ctrl.sv
// Bench for can_error_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a countdown-style behavioural model.
module tb_can_error_ctrl;

  localparam int FLAG_LEN  = 6;
  localparam int DELIM_LEN = 8;
  localparam int RECOV_CNT = 128;
  localparam logic [3:0] NOERR = 4'b1111;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic SP = 1'b0, STF_E = 1'b1, EOF_E = 1'b1, CRC_E = 1'b1, FRM_E = 1'b1;
  logic RX_BIT = 1'b1, TX_MODE = 1'b0, FRAME_OK = 1'b0;
  logic TX_BIT, ERR_BUSY, RESTART;
  logic [8:0] TEC;
  logic [7:0] REC;
  logic [1:0] NODE_STATE;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  can_error_ctrl #(
    .FLAG_LEN (FLAG_LEN),
    .DELIM_LEN(DELIM_LEN),
    .RECOV_CNT(RECOV_CNT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .SP        (SP),
    .STF_E     (STF_E),
    .EOF_E     (EOF_E),
    .CRC_E     (CRC_E),
    .FRM_E     (FRM_E),
    .RX_BIT    (RX_BIT),
    .TX_MODE   (TX_MODE),
    .FRAME_OK  (FRAME_OK),
    .TX_BIT    (TX_BIT),
    .ERR_BUSY  (ERR_BUSY),
    .TEC       (TEC),
    .REC       (REC),
    .NODE_STATE(NODE_STATE),
    .RESTART   (RESTART)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an error frame is "flag bits left", "waiting for a
  // recessive bit" and "delimiter bits left"; bus-off is a run/sequence tally.
  int m_tec, m_rec, m_flag_left, m_delim_left, m_run, m_seqs;
  bit m_wait, m_busoff, m_flag_lvl, m_restart;
  bit m_valid = 1'b0;

  always @(posedge clock) begin
    bit ev, busy, err;
    if (!reset) begin
      m_tec = 0; m_rec = 0; m_flag_left = 0; m_delim_left = 0;
      m_wait = 0; m_busoff = 0; m_run = 0; m_seqs = 0;
      m_flag_lvl = 0; m_restart = 0; m_valid = 1;
    end else if (m_valid) begin
      m_restart = 0;
      ev = SP && !(STF_E && EOF_E && CRC_E && FRM_E);
      if (m_busoff) begin
        if (SP) begin
          if (!RX_BIT) m_run = 0;
          else begin
            m_run++;
            if (m_run == 11) begin
              m_run = 0;
              m_seqs++;
              if (m_seqs == RECOV_CNT) begin
                m_seqs = 0; m_tec = 0; m_rec = 0; m_busoff = 0; m_restart = 1;
              end
            end
          end
        end
      end else begin
        busy = (m_flag_left > 0) || m_wait || (m_delim_left > 0);
        if (!busy) err = ev;
        else err = (m_delim_left > 0) && SP && (ev || !RX_BIT);
        if (err) begin
          if (TX_MODE) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
          else m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
          m_wait = 0;
          m_delim_left = 0;
          if (m_tec >= 256) begin
            m_busoff = 1; m_flag_left = 0; m_run = 0; m_seqs = 0;
          end else begin
            m_flag_left = FLAG_LEN;
            m_flag_lvl = (m_tec >= 128) || (m_rec >= 128);
          end
        end else if (FRAME_OK && !busy) begin
          if (TX_MODE) begin
            if (m_tec > 0) m_tec--;
          end else if (m_rec > 127) m_rec = 120;
          else if (m_rec > 0) m_rec--;
        end else if (SP) begin
          if (m_flag_left > 0) begin
            m_flag_left--;
            if (m_flag_left == 0) m_wait = 1;
          end else if (m_wait) begin
            if (RX_BIT) begin
              m_wait = 0;
              m_delim_left = DELIM_LEN - 1;
            end
          end else if (m_delim_left > 0) m_delim_left--;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("m_tx_bit", TX_BIT, m_busoff ? 1 : ((m_flag_left > 0) ? m_flag_lvl : 1));
      chk("m_err_busy", ERR_BUSY, !m_busoff && ((m_flag_left > 0) || m_wait || (m_delim_left > 0)));
      chk("m_tec", TEC, m_tec);
      chk("m_rec", REC, m_rec);
      chk("m_node", NODE_STATE, (m_tec >= 256) ? 2 : ((m_tec >= 128 || m_rec >= 128) ? 1 : 0));
      chk("m_restart", RESTART, m_restart);
    end
  end

  task automatic step(input bit sp, input logic [3:0] errn, input bit rx, input bit txm, input bit ok);
    SP = sp;
    {STF_E, EOF_E, CRC_E, FRM_E} = errn;
    RX_BIT = rx;
    TX_MODE = txm;
    FRAME_OK = ok;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(0, NOERR, 1, 0, 0);
    reset = 1'b1;
  endtask

  task automatic finish_frame(input bit txm);
    int g;
    g = 0;
    while (ERR_BUSY && g < 60) begin
      step(1, NOERR, TX_BIT, txm, 0);
      g++;
    end
    chk("frame_end", ERR_BUSY, 0);
  endtask

  task automatic count_flag(input string name);
    int n, g;
    n = 0;
    g = 0;
    while (TX_BIT == 1'b0 && g < 20) begin
      n++;
      g++;
      step(1, NOERR, 0, TX_MODE, 0);
    end
    chk(name, n, FLAG_LEN);
  endtask

  initial begin
    int n;
    bit seen;

    repeat (3) @(negedge clock);
    reset = 1'b1;
    chk("rst_tx", TX_BIT, 1);
    chk("rst_busy", ERR_BUSY, 0);
    chk("rst_tec", TEC, 0);
    chk("rst_rec", REC, 0);
    chk("rst_node", NODE_STATE, 0);
    chk("rst_restart", RESTART, 0);

    // Receiver CRC error: one full active error frame
    step(1, 4'b1101, 1, 0, 0);
    chk("rx_rec", REC, 1);
    chk("rx_busy", ERR_BUSY, 1);
    count_flag("rx_flag_len");
    for (int i = 0; i < DELIM_LEN - 1; i++) step(1, NOERR, 1, 0, 0);
    chk("rx_delim_busy", ERR_BUSY, 1);
    step(1, NOERR, 1, 0, 0);
    chk("rx_delim_end", ERR_BUSY, 0);
    chk("rx_node", NODE_STATE, 0);

    // Transmitter: 16 error frames take TEC to the passive limit
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(1, 4'b0111, 1, 1, 0);
      finish_frame(1);
    end
    chk("tx16_tec", TEC, 128);
    chk("tx16_node", NODE_STATE, 1);
    step(1, 4'b1110, 1, 1, 0);
    chk("tx17_tec", TEC, 136);
    chk("tx17_busy", ERR_BUSY, 1);
    chk("tx17_passive_flag", TX_BIT, 1);
    finish_frame(1);

    // Receiver passive reload and error-beats-FRAME_OK
    do_reset();
    for (int k = 0; k < 130; k++) begin
      step(1, 4'b1011, 1, 0, 0);
      finish_frame(0);
    end
    chk("rec130", REC, 130);
    chk("rec130_node", NODE_STATE, 1);
    step(0, NOERR, 1, 0, 1);
    chk("rec_reload", REC, 120);
    chk("rec_reload_node", NODE_STATE, 0);
    step(1, 4'b0111, 1, 0, 1);
    chk("err_beats_ok", REC, 121);
    finish_frame(0);

    // Bus-off entry and recovery
    do_reset();
    for (int k = 0; k < 31; k++) begin
      step(1, 4'b1110, 1, 1, 0);
      finish_frame(1);
    end
    chk("tec248", TEC, 248);
    for (int k = 0; k < 6; k++) step(0, NOERR, 1, 1, 1);
    step(1, 4'b1110, 1, 1, 0);
    finish_frame(1);
    chk("tec250", TEC, 250);
    step(1, 4'b1110, 1, 1, 0);
    chk("busoff_tec", TEC, 256);
    chk("busoff_node", NODE_STATE, 2);
    chk("busoff_tx", TX_BIT, 1);
    chk("busoff_busy", ERR_BUSY, 0);
    for (int k = 0; k < 4; k++) step(1, NOERR, 1, 1, 0);
    step(1, 4'b0000, 1, 1, 1);
    step(1, NOERR, 0, 1, 0);
    chk("busoff_hold", TEC, 256);
    n = 0;
    seen = 0;
    while (!seen && n < 2000) begin
      step(1, NOERR, 1, 1, 0);
      n++;
      if (RESTART) seen = 1;
    end
    chk("restart_seen", seen, 1);
    chk("recov_bits", n, RECOV_CNT * 11);
    chk("recov_tec", TEC, 0);
    chk("recov_rec", REC, 0);
    chk("recov_node", NODE_STATE, 0);
    step(0, NOERR, 1, 1, 0);
    chk("restart_pulse", RESTART, 0);

    // Dominant bit inside the delimiter restarts the flag
    do_reset();
    step(1, 4'b1011, 1, 0, 0);
    for (int k = 0; k < FLAG_LEN; k++) step(1, NOERR, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1, NOERR, 1, 0, 0);
    step(1, NOERR, 0, 0, 0);
    chk("form_rec", REC, 2);
    chk("form_tx", TX_BIT, 0);
    count_flag("form_flag_len");
    finish_frame(0);

    // Reset in the middle of a flag
    do_reset();
    step(1, 4'b1110, 1, 1, 0);
    chk("midflag_tec", TEC, 8);
    step(1, NOERR, 0, 1, 0);
    step(1, NOERR, 0, 1, 0);
    reset = 1'b0;
    step(1, NOERR, 0, 1, 0);
    reset = 1'b1;
    chk("midrst_tx", TX_BIT, 1);
    chk("midrst_busy", ERR_BUSY, 0);
    chk("midrst_tec", TEC, 0);
    chk("midrst_rec", REC, 0);
    step(1, NOERR, 0, 1, 0);
    chk("midrst_no_resume", TX_BIT, 1);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic [3:0] errn;
      errn = ($urandom_range(0, 19) == 0) ? 4'($urandom) : NOERR;
      reset = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      step($urandom_range(0, 1), errn, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    reset = 1'b1;
    step(0, NOERR, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/can_error_ctrl.md
# can_error_ctrl

Fault-confinement and error-frame controller for the CAN decoder. It consumes the per-bit error flags from the error block at each sample point and maintains the transmit (TEC) and receive (REC) error counters. It derives the node state (error-active / error-passive / bus-off), sequences the error flag and delimiter onto the transmit bit, and runs bus-off recovery. It sits between the error block and the bit-level transmit path.

## Interface
Parameters:
- FLAG_LEN, 6, error-flag length in bit times
- DELIM_LEN, 8, error-delimiter length in recessive bit times
- RECOV_CNT, 128, number of 11-recessive-bit sequences required to leave bus-off (reducible for simulation)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low; all state cleared on the rising clock edge while low
- SP  in  1  sample-point strobe, one clock per bit time
- STF_E, EOF_E, CRC_E, FRM_E  in  1 each  error flags, active-low, valid only when SP=1
- RX_BIT  in  1  bus level at SP (0 = dominant)
- TX_MODE  in  1  node is transmitter of the current frame
- FRAME_OK  in  1  one-clock pulse when a frame completes without error
- TX_BIT  out  1  bit driven to bus (1 = recessive)
- ERR_BUSY  out  1  error flag or delimiter in progress
- TEC  out  9  transmit error counter, 0..256
- REC  out  8  receive error counter, 0..255
- NODE_STATE  out  2  00 active, 01 passive, 10 bus-off
- RESTART  out  1  one-clock pulse on bus-off recovery

## Operation
- An error event is SP=1 with any of STF_E/EOF_E/CRC_E/FRM_E low. Simultaneous flags count as one event.
- Counter update on an error event:
  - TX_MODE=1: TEC += 8, clamped at 256.
  - TX_MODE=0: REC += 1, clamped at 255.
- Counter update on FRAME_OK:
  - TX_MODE=1: TEC -= 1 if TEC>0.
  - TX_MODE=0: REC -= 1 if 1≤REC≤127; REC := 120 if REC>127.
  - FRAME_OK is ignored while ERR_BUSY=1 or in bus-off.
- Error event and FRAME_OK in the same clock: the error wins and FRAME_OK is dropped.
- NODE_STATE is combinational from the counters:
  - bus-off if TEC≥256
  - else passive if TEC≥128 or REC≥128
  - else active
- Sequencer FSM states: IDLE, FLAG, WAIT_DELIM, DELIM, BUSOFF.
  - IDLE: TX_BIT=1. Error event → FLAG with bit count 0.
  - FLAG: TX_BIT=0 if active, 1 if passive. Counts SPs; after FLAG_LEN SPs → WAIT_DELIM.
  - WAIT_DELIM: TX_BIT=1. First SP with RX_BIT=1 → DELIM with count 1.
  - DELIM: TX_BIT=1. Counts recessive SPs; at DELIM_LEN → IDLE.
  - RX_BIT=0 at SP during DELIM is a form error: counter update as above, then → FLAG with count 0.
  - Any state: if the counter update yields TEC≥256 → BUSOFF, overriding all other transitions.
  - BUSOFF: TX_BIT=1, error inputs and FRAME_OK ignored. A 4-bit run counter counts consecutive SPs with RX_BIT=1 and clears on RX_BIT=0. At 11 it clears and an occurrence counter increments. When the occurrence counter reaches RECOV_CNT: TEC:=0, REC:=0, → IDLE, RESTART=1 for one clock.
- Error flags arriving during FLAG or WAIT_DELIM are ignored; the flag superposition belongs to the same error.
- ERR_BUSY=1 in FLAG, WAIT_DELIM and DELIM.

## Timing
- All outputs are registered except NODE_STATE, which decodes from registered counters.
- Reset values: TX_BIT=1, ERR_BUSY=0, TEC=0, REC=0, NODE_STATE=00, RESTART=0, FSM=IDLE, all internal counters 0.
- Counter and FSM updates take effect on the clock edge at which SP/FRAME_OK is sampled; the new values are visible the next clock.
- The first flag bit is driven from the clock after the detecting SP and holds across FLAG_LEN bit times.
- Reset low mid-flag or mid-recovery: reset values are restored on that edge and no partial sequence resumes.

## Structure
- Shared package can_err_pkg holds:
  - FSM state encoding and NODE_STATE codes
  - limits: PASSIVE_LIM=128, BUSOFF_LIM=256, RECOV_RUN=11
  - increment constants: TX_INC=8, RX_INC=1, REC_RELOAD=120
- One sub-module, can_err_counters, holds the TEC/REC arithmetic, saturation and NODE_STATE decode. The top level holds the sequencer FSM and the recovery counters.

## Test plan
- Receiver, CRC_E low at one SP → REC=1, TX_BIT=0 for exactly 6 SPs, then 8 recessive SPs, ERR_BUSY falls; NODE_STATE=00.
- Transmitter, 16 error events each followed by a full error frame → TEC=128, NODE_STATE=01, the 17th flag drives TX_BIT=1 (passive flag).
- REC=130, receiver FRAME_OK → REC=120, NODE_STATE=00; FRAME_OK in the same clock as STF_E low → REC increments only.
- TEC=250, transmitter error → TEC=256, NODE_STATE=10, BUSOFF; 128×11 recessive SPs (one dominant bit inserted mid-run) → RESTART pulse, TEC=REC=0, IDLE.
- Dominant RX_BIT during DELIM → REC+1, FLAG restarts with 6 new flag bits.
- reset low during FLAG → next clock TX_BIT=1, ERR_BUSY=0, TEC=REC=0.
